// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP32 divider (and the multiplier that reuses
// fp_round): FSM state encoding, rounding-mode codes, FP32 field widths,
// special constants and the special-operand decode helpers.
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;   // fraction plus hidden bit

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        DIV     = 3'd2,
        ROUND   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Any operand with a reserved exponent (zero/subnormal, Inf, NaN)
    // bypasses the iterative divider.
    function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    // Result for operand pairs accepted by is_special.
    function automatic logic [31:0] special_result(input logic [31:0] x, input logic [31:0] y);
        logic s, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        s      = x[31] ^ y[31];
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
            return QNAN;
        else if (x_inf || y_zero)
            return {s, 8'hFF, 23'd0};
        else
            return {s, 31'd0};
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// ---------------------------------------------------------------------------
// fp_div_seq_if
// Start/done handshake and operand/result bundle of the sequential divider.
//   start, fp_X, fp_Y, r_mode : request side (driven by master)
//   busy, done, fp_Z, ovrf, udrf : response side (driven by slave)
// ---------------------------------------------------------------------------
interface fp_div_seq_if;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        busy;
    logic        done;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    modport master (
        output start, fp_X, fp_Y, r_mode,
        input  busy, done, fp_Z, ovrf, udrf
    );

    modport slave (
        input  start, fp_X, fp_Y, r_mode,
        output busy, done, fp_Z, ovrf, udrf
    );
endinterface

// File: rtl/fp_round.sv
// ---------------------------------------------------------------------------
// fp_round
// Combinational FP32 rounding / packing stage.
//   i_sign   : result sign
//   i_exp    : biased exponent, 10-bit signed (may be out of range)
//   i_mant   : normalised 24-bit mantissa (hidden bit in [23])
//   i_g/i_r  : guard and round bits below the mantissa LSB
//   i_sticky : OR of everything below the round bit
//   i_rmode  : rounding mode (unknown codes behave as RNE)
//   o_fp_z   : packed result; o_ovrf / o_udrf : range flags
// ---------------------------------------------------------------------------
module fp_round
    import fp_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [23:0]       i_mant,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_sticky,
    input  logic [2:0]        i_rmode,
    output logic [31:0]       o_fp_z,
    output logic              o_ovrf,
    output logic              o_udrf
);
    logic              w_inexact;
    logic              w_up;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_f;
    logic [22:0]       w_frac_f;

    assign w_inexact = i_g | i_r | i_sticky;

    always_comb begin
        w_up = 1'b0;
        case (i_rmode)
            RM_RTZ:  w_up = 1'b0;
            RM_RDN:  w_up = i_sign & w_inexact;
            RM_RUP:  w_up = ~i_sign & w_inexact;
            RM_RMM:  w_up = i_g;
            default: w_up = i_g & (i_r | i_sticky | i_mant[0]);
        endcase
    end

    assign w_sum   = {1'b0, i_mant} + 25'(w_up);
    // Carry-out means the mantissa became 2.0: bump the exponent. The hidden
    // bit position then reads 0 and the fraction of 1.0 is all zeros.
    assign w_exp_f  = i_exp + $signed({9'd0, w_sum[24]});
    assign w_frac_f = w_sum[23] ? w_sum[22:0] : 23'd0;

    always_comb begin
        o_fp_z = {i_sign, w_exp_f[7:0], w_frac_f};
        o_ovrf = 1'b0;
        o_udrf = 1'b0;
        if (w_exp_f >= 10'sd255) begin
            o_ovrf = 1'b1;
            case (i_rmode)
                RM_RTZ:  o_fp_z = {i_sign, MAXF[30:0]};
                RM_RDN:  o_fp_z = i_sign ? {1'b1, 8'hFF, 23'd0} : MAXF;
                RM_RUP:  o_fp_z = i_sign ? {1'b1, MAXF[30:0]} : {1'b0, 8'hFF, 23'd0};
                default: o_fp_z = {i_sign, 8'hFF, 23'd0};
            endcase
        end else if (w_exp_f <= 10'sd0) begin
            o_udrf = 1'b1;
            o_fp_z = {i_sign, 31'd0};
        end
    end
endmodule

// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq
// Sequential FP32 divider fp_Z = fp_X / fp_Y, radix-2 restoring, one
// quotient bit per cycle (26 iterations: 24 mantissa bits + guard + round).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fp_div_seq_if.slave (start/fp_X/fp_Y/r_mode in,
//          busy/done/fp_Z/ovrf/udrf out)
// Special operand pairs take IDLE->SPECIAL->DONE (done 2 cycles after
// acceptance); normal pairs take IDLE->DIV(x26)->ROUND->DONE (28 cycles).
// ---------------------------------------------------------------------------
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_div_seq_if.slave  bus
);
    state_t            r_state;
    state_t            w_state_next;

    logic [31:0]       r_x;
    logic [31:0]       r_y;
    logic [2:0]        r_rmode;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_div;
    logic [24:0]       r_rem;
    logic [25:0]       r_quo;
    logic [4:0]        r_cnt;
    logic [31:0]       r_fp_z;
    logic              r_ovrf;
    logic              r_udrf;

    logic              w_start_ok;
    logic [23:0]       w_mx;
    logic [23:0]       w_my;
    logic signed [9:0] w_exp0;
    logic              w_x_lt_y;
    logic              w_ge;
    logic [24:0]       w_rem_sub;
    logic [31:0]       w_round_z;
    logic              w_round_ovrf;
    logic              w_round_udrf;

    assign w_start_ok = (r_state == IDLE) && bus.start;

    // Operand setup at acceptance
    assign w_mx     = {1'b1, bus.fp_X[22:0]};
    assign w_my     = {1'b1, bus.fp_Y[22:0]};
    assign w_exp0   = $signed({2'b00, bus.fp_X[30:23]}) - $signed({2'b00, bus.fp_Y[30:23]}) + 10'sd127;
    assign w_x_lt_y = (w_mx < w_my);

    // One restoring step: the remainder always stays below the divisor after
    // the subtract, so the left shift fits back into 25 bits.
    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    fp_round u_round (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_mant   (r_quo[25:2]),
        .i_g      (r_quo[1]),
        .i_r      (r_quo[0]),
        .i_sticky (|r_rem),
        .i_rmode  (r_rmode),
        .o_fp_z   (w_round_z),
        .o_ovrf   (w_round_ovrf),
        .o_udrf   (w_round_udrf)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)
                         w_state_next = is_special(bus.fp_X, bus.fp_Y) ? SPECIAL : DIV;
            SPECIAL: w_state_next = DONE;
            DIV:     if (r_cnt == 5'd25) w_state_next = ROUND;
            ROUND:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (r_state == SPECIAL) || (r_state == DIV) || (r_state == ROUND);
        bus.done = (r_state == DONE);
        bus.fp_Z = r_fp_z;
        bus.ovrf = r_ovrf;
        bus.udrf = r_udrf;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_rmode <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_fp_z  <= '0;
            r_ovrf  <= 1'b0;
            r_udrf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start_ok) begin
                        r_x     <= bus.fp_X;
                        r_y     <= bus.fp_Y;
                        r_rmode <= bus.r_mode;
                        r_sign  <= bus.fp_X[31] ^ bus.fp_Y[31];
                        r_div   <= w_my;
                        r_quo   <= '0;
                        // Pre-normalise so the quotient lands in [1,2)
                        if (w_x_lt_y) begin
                            r_rem <= {w_mx, 1'b0};
                            r_exp <= w_exp0 - 10'sd1;
                        end else begin
                            r_rem <= {1'b0, w_mx};
                            r_exp <= w_exp0;
                        end
                    end
                end
                DIV: begin
                    r_quo <= {r_quo[24:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                SPECIAL: begin
                    r_fp_z <= special_result(r_x, r_y);
                    r_ovrf <= 1'b0;
                    r_udrf <= 1'b0;
                end
                ROUND: begin
                    r_fp_z <= w_round_z;
                    r_ovrf <= w_round_ovrf;
                    r_udrf <= w_round_udrf;
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_ops    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %08h required %08h", tag, obs, exp_v);
    endtask

    // Reference: exact integer quotient of the mantissas, rounded from the
    // discarded tail compared against one half ULP.
    function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        logic        s, up, inexact;
        int          ex, ey, e, drop;
        logic [63:0] num, den, q, rem, kept, tail, half;
        bit          xz, yz, xi, yi, xn, yn;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);  yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {2'b00, 32'h7FC00000};
        if (xi || yz) return {2'b00, s, 8'hFF, 23'h0};
        if (xz || yi) return {2'b00, s, 31'h0};
        num = {40'h0, 1'b1, x[22:0]} << 40;
        den = {40'h0, 1'b1, y[22:0]};
        q   = num / den;
        rem = num % den;
        e   = ex - ey + 127;
        if (q >= (64'd1 << 40)) drop = 17;
        else begin drop = 16; e = e - 1; end
        kept    = q >> drop;
        tail    = q & ((64'd1 << drop) - 64'd1);
        half    = 64'd1 << (drop - 1);
        inexact = (tail != 0) || (rem != 0);
        case (m)
            3'd1:    up = 1'b0;
            3'd2:    up = s && inexact;
            3'd3:    up = !s && inexact;
            3'd4:    up = (tail >= half);
            default: up = (tail > half) || ((tail == half) && ((rem != 0) || kept[0]));
        endcase
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; e = e + 1; end
        if (e >= 255) begin
            case (m)
                3'd1:    return {2'b10, s, 31'h7F7FFFFF};
                3'd2:    return {2'b10, (s ? 32'hFF800000 : 32'h7F7FFFFF)};
                3'd3:    return {2'b10, (s ? 32'hFF7FFFFF : 32'h7F800000)};
                default: return {2'b10, s, 8'hFF, 23'h0};
            endcase
        end
        if (e <= 0) return {2'b01, s, 31'h0};
        return {2'b00, s, 8'(e), kept[22:0]};
    endfunction

    function automatic bit ref_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 0) || (x[30:23] == 255) || (y[30:23] == 0) || (y[30:23] == 255);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = int'($urandom_range(0, 11));
        case (sel)
            0: v[30:0] = 31'h0;                                    // zero
            1: v[30:0] = {8'h00, v[22:0]};                         // subnormal
            2: v[30:0] = {8'hFF, 23'h0};                           // Inf
            3: v[30:0] = {8'hFF, v[22:0] | 23'h1};                 // NaN
            4, 5: v[30:23] = 8'($urandom_range(1, 30));            // tiny
            6, 7: v[30:23] = 8'($urandom_range(225, 254));         // huge
            8: begin v[30:23] = 8'($urandom_range(100, 154)); v[11:0] = 12'h0; end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // One transaction: start in cycle 0, optional stray start pulse at
    // cycle poke_cyc, optional stray start in the done cycle.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                          input logic [33:0] exp_r, input int poke_cyc, input bit poke_done);
        int lat, exp_lat, busy_bad;
        exp_lat  = ref_special(x, y) ? 2 : 28;
        lat      = 0;
        busy_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.fp_X = x; bus.fp_Y = y; bus.r_mode = m;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0; bus.fp_X = $urandom; bus.fp_Y = $urandom; bus.r_mode = 3'($urandom);
            end
            if (bus.done) begin lat = n; break; end
            if (!bus.busy) busy_bad++;
            if (n == poke_cyc) begin
                bus.start = 1'b1; bus.fp_X = $urandom; bus.fp_Y = $urandom;
            end
            if (n == poke_cyc + 1) bus.start = 1'b0;
        end
        n_ops++;
        $display("op %0d: %08h / %08h rm=%0d -> Z=%08h ovrf=%0b udrf=%0b lat=%0d (ref %08h %0b %0b)",
                 n_ops, x, y, m, bus.fp_Z, bus.ovrf, bus.udrf, lat, exp_r[31:0], exp_r[33], exp_r[32]);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_during_op", 32'(busy_bad), 32'd0);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("fp_Z", bus.fp_Z, exp_r[31:0]);
        check("ovrf", 32'(bus.ovrf), 32'(exp_r[33]));
        check("udrf", 32'(bus.udrf), 32'(exp_r[32]));
        if (poke_done) begin
            bus.start = 1'b1; bus.fp_X = 32'h3F800000; bus.fp_Y = 32'h40000000;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("fp_Z_held", bus.fp_Z, exp_r[31:0]);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  m;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } vec_t;

    vec_t dir_vecs[$] = '{
        '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0},
        '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 1'b0, 1'b0},
        '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 1'b0, 1'b0},
        '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 1'b0, 1'b0},
        '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0},
        '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 1'b0, 1'b0},
        '{32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 1'b1, 1'b0},
        '{32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0},
        '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 1'b0, 1'b1}
    };

    initial begin
        int done_seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.fp_X = '0; bus.fp_Y = '0; bus.r_mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_fp_Z", bus.fp_Z, 32'd0);
        check("reset_ovrf", 32'(bus.ovrf), 32'd0);
        check("reset_udrf", 32'(bus.udrf), 32'd0);

        // Directed cases; the first one also sees a stray start at cycle 5
        foreach (dir_vecs[i])
            run_op(dir_vecs[i].x, dir_vecs[i].y, dir_vecs[i].m,
                   {dir_vecs[i].ov, dir_vecs[i].ud, dir_vecs[i].z},
                   (i == 0) ? 5 : 0, (i == 1));

        // Abort by reset at cycle 10 of a normal operation
        @(negedge clk);
        bus.start = 1'b1; bus.fp_X = 32'h40C00000; bus.fp_Y = 32'h40000000; bus.r_mode = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_ops++;
        $display("op %0d: reset at cycle 10 -> busy=%0b done=%0b Z=%08h ovrf=%0b udrf=%0b",
                 n_ops, bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_fp_Z", bus.fp_Z, 32'd0);
        check("abort_ovrf", 32'(bus.ovrf), 32'd0);
        check("abort_udrf", 32'(bus.udrf), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Randomized operands and rounding modes against the reference
        for (int k = 0; k < 250; k++) begin
            logic [31:0] x, y;
            logic [2:0]  m;
            x = rand_operand();
            y = rand_operand();
            m = 3'($urandom_range(0, 7));
            run_op(x, y, m, ref_div(x, y, m),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0,
                   bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
